ahb_mem_slave: RTL and testbench

AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

---
 rtl/ahb_mem_slave.sv | 131 +++++++++++++
 tb/tb_ahb_mem_slave.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: word-organised RAM with byte/halfword/word writes,
// programmable wait states, two-cycle ERROR response and a saturating error counter.
module ahb_mem_slave #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_STATES = 1
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic [1:0]  HRESP,
   output logic [31:0] HRDATA,
   output logic [7:0]  err_cnt
);

   localparam int          AW         = $clog2(DEPTH_WORDS);
   localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
   localparam logic [1:0]  RESP_OKAY  = 2'b00;
   localparam logic [1:0]  RESP_ERROR = 2'b01;

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

   state_t          state;
   logic [2:0]      cnt;
   logic            hready_q;
   logic [1:0]      hresp_q;
   logic [7:0]      err_cnt_q;

   logic [AW-1:0]   idx_p1;
   logic            write_p1;
   logic [1:0]      size_p1;
   logic [1:0]      off_p1;
   logic [3:0]      be_p1;

   logic [31:0]     mem [DEPTH_WORDS];

   logic            final_data;
   logic            can_accept;
   logic            accept;
   logic            addr_err;
   logic            unused_ok;

   assign unused_ok  = ^{HBURST, HPROT, HTRANS[0]};

   assign final_data = (state == S_DATA) && (cnt == 3'd0);
   assign can_accept = (state == S_IDLE) || (state == S_ERR2) || final_data;
   assign accept     = HSEL && HTRANS[1] && HREADY && can_accept;
   assign addr_err   = (HADDR >= ADDR_LIMIT) ||
                       (HSIZE > 3'b010) ||
                       ((HSIZE == 3'b001) && HADDR[0]) ||
                       ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));

   // Control FSM; outputs are registered alongside the state they belong to
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= S_IDLE;
         cnt       <= 3'd0;
         hready_q  <= 1'b1;
         hresp_q   <= RESP_OKAY;
         err_cnt_q <= 8'd0;
      end else if (state == S_ERR1) begin
         state    <= S_ERR2;
         hready_q <= 1'b1;
         hresp_q  <= RESP_ERROR;
      end else if ((state == S_DATA) && (cnt != 3'd0)) begin
         cnt      <= cnt - 3'd1;
         hready_q <= (cnt == 3'd1);
      end else if (accept && !addr_err) begin
         state    <= S_DATA;
         cnt      <= 3'(WAIT_STATES);
         hready_q <= (WAIT_STATES == 0);
         hresp_q  <= RESP_OKAY;
      end else if (accept) begin
         state    <= S_ERR1;
         cnt      <= 3'd0;
         hready_q <= 1'b0;
         hresp_q  <= RESP_ERROR;
         if (err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'd1;
      end else begin
         state    <= S_IDLE;
         cnt      <= 3'd0;
         hready_q <= 1'b1;
         hresp_q  <= RESP_OKAY;
      end
   end

   // Address phase -> data phase
   always_ff @(posedge HCLK) begin
      if (accept) begin
         idx_p1   <= HADDR[AW+1:2];
         write_p1 <= HWRITE;
         size_p1  <= HSIZE[1:0];
         off_p1   <= HADDR[1:0];
      end
   end

   // Only legal sizes ever reach the data phase, so size_p1 never holds 2'b11
   always_comb begin
      be_p1 = 4'b1111;
      case (size_p1)
         2'b00:   be_p1 = 4'b0001 << off_p1;
         2'b01:   be_p1 = off_p1[1] ? 4'b1100 : 4'b0011;
         default: be_p1 = 4'b1111;
      endcase
   end

   // Write commits on the edge that closes the final data-phase cycle
   always_ff @(posedge HCLK) begin
      if (final_data && write_p1) begin
         for (int i = 0; i < 4; i++) begin
            if (be_p1[i])
               mem[idx_p1][8*i +: 8] <= HWDATA[8*i +: 8];
         end
      end
   end

   assign HREADYOUT = hready_q;
   assign HRESP     = hresp_q;
   assign err_cnt   = err_cnt_q;
   assign HRDATA    = ((state == S_DATA) && !write_p1) ? mem[idx_p1] : 32'd0;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench for ahb_mem_slave: one instance with one wait state, one with none.
module tb_ahb_mem_slave;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        hsel0, hsel1;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic [31:0] HWDATA;

   logic        hreadyout0, hreadyout1;
   logic [1:0]  hresp0, hresp1;
   logic [31:0] hrdata0, hrdata1;
   logic [7:0]  err_cnt0, err_cnt1;

   int vecs  = 0;
   int fails = 0;

   always #5 HCLK = ~HCLK;

   ahb_mem_slave #(.DEPTH_WORDS(64), .WAIT_STATES(1)) dut0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
      .HREADY(hreadyout0), .HREADYOUT(hreadyout0), .HRESP(hresp0), .HRDATA(hrdata0),
      .err_cnt(err_cnt0)
   );

   ahb_mem_slave #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut1 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel1), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
      .HREADY(hreadyout1), .HREADYOUT(hreadyout1), .HRESP(hresp1), .HRDATA(hrdata1),
      .err_cnt(err_cnt1)
   );

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic start(input logic s0, input logic s1, input logic [31:0] a,
                        input logic w, input logic [2:0] s);
      hsel0  = s0;
      hsel1  = s1;
      HADDR  = a;
      HTRANS = 2'b10;
      HWRITE = w;
      HSIZE  = s;
   endtask

   task automatic stop();
      hsel0  = 1'b0;
      hsel1  = 1'b0;
      HTRANS = 2'b00;
   endtask

   // Complete single transfer on dut0; returns final-cycle data/response and wait count
   task automatic xfer0(input logic [31:0] a, input logic w, input logic [2:0] s,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic [1:0] rs, output int waits);
      start(1'b1, 1'b0, a, w, s);
      tick();
      stop();
      HWDATA = wd;
      waits  = 0;
      rd     = '0;
      rs     = '0;
      for (int i = 0; i < 16; i++) begin
         @(negedge HCLK);
         rd = hrdata0;
         rs = hresp0;
         if (hreadyout0) break;
         waits++;
      end
      if (!hreadyout0) waits = 99;
      tick();
   endtask

   task automatic test_reset();
      @(negedge HCLK);
      vecs++;
      if ({hreadyout0, hresp0, hrdata0, err_cnt0} !== {1'b1, 2'b00, 32'd0, 8'd0}) begin
         fails++;
         $display("FAIL reset_dut0: got %h want %h", {hreadyout0, hresp0, hrdata0, err_cnt0},
                  {1'b1, 2'b00, 32'd0, 8'd0});
      end
      vecs++;
      if ({hreadyout1, hresp1, hrdata1, err_cnt1} !== {1'b1, 2'b00, 32'd0, 8'd0}) begin
         fails++;
         $display("FAIL reset_dut1: got %h want %h", {hreadyout1, hresp1, hrdata1, err_cnt1},
                  {1'b1, 2'b00, 32'd0, 8'd0});
      end
      tick();
      HRESETn = 1'b1;
      tick();
   endtask

   task automatic test_write_read();
      logic [31:0] rd;
      logic [1:0]  rs;
      int          waits;
      xfer0(32'h10, 1'b1, 3'b010, 32'hDEADBEEF, rd, rs, waits);
      vecs++;
      if (waits !== 1 || rs !== 2'b00) begin
         fails++;
         $display("FAIL wr_word_waits: got waits=%0d resp=%b want waits=1 resp=00", waits, rs);
      end
      xfer0(32'h10, 1'b0, 3'b010, 32'h0, rd, rs, waits);
      vecs++;
      if (waits !== 1 || rs !== 2'b00 || rd !== 32'hDEADBEEF) begin
         fails++;
         $display("FAIL rd_word: got waits=%0d resp=%b data=%h want 1 00 deadbeef", waits, rs, rd);
      end
      @(negedge HCLK);
      vecs++;
      if (hrdata0 !== 32'd0 || hreadyout0 !== 1'b1) begin
         fails++;
         $display("FAIL idle_hrdata: got data=%h rdy=%b want 0 1", hrdata0, hreadyout0);
      end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd;
      logic [1:0]  rs;
      int          waits;
      xfer0(32'h20, 1'b1, 3'b010, 32'h11223344, rd, rs, waits);
      xfer0(32'h21, 1'b1, 3'b000, 32'h0000AA00, rd, rs, waits);
      xfer0(32'h20, 1'b0, 3'b010, 32'h0, rd, rs, waits);
      vecs++;
      if (rd !== 32'h1122AA44) begin
         fails++;
         $display("FAIL byte_lane: got %h want 1122aa44", rd);
      end
      xfer0(32'h22, 1'b1, 3'b001, 32'hBEEF5555, rd, rs, waits);
      xfer0(32'h20, 1'b0, 3'b010, 32'h0, rd, rs, waits);
      vecs++;
      if (rd !== 32'hBEEFAA44) begin
         fails++;
         $display("FAIL half_lane: got %h want beefaa44", rd);
      end
      xfer0(32'h23, 1'b1, 3'b000, 32'h77000000, rd, rs, waits);
      xfer0(32'h20, 1'b0, 3'b010, 32'h0, rd, rs, waits);
      vecs++;
      if (rd !== 32'h77EFAA44) begin
         fails++;
         $display("FAIL top_byte_lane: got %h want 77efaa44", rd);
      end
   endtask

   task automatic test_error();
      logic [31:0] rd;
      logic [1:0]  rs;
      int          waits;
      xfer0(32'h0, 1'b1, 3'b010, 32'h12345678, rd, rs, waits);
      start(1'b1, 1'b0, 32'h100, 1'b0, 3'b010);
      tick();
      stop();
      @(negedge HCLK);
      vecs++;
      if ({hreadyout0, hresp0, err_cnt0} !== {1'b0, 2'b01, 8'd1}) begin
         fails++;
         $display("FAIL err1_phase: got %h want %h", {hreadyout0, hresp0, err_cnt0},
                  {1'b0, 2'b01, 8'd1});
      end
      tick();
      @(negedge HCLK);
      vecs++;
      if ({hreadyout0, hresp0, hrdata0} !== {1'b1, 2'b01, 32'd0}) begin
         fails++;
         $display("FAIL err2_phase: got %h want %h", {hreadyout0, hresp0, hrdata0},
                  {1'b1, 2'b01, 32'd0});
      end
      tick();
      @(negedge HCLK);
      vecs++;
      if ({hreadyout0, hresp0} !== {1'b1, 2'b00}) begin
         fails++;
         $display("FAIL err_return_idle: got %b want 100", {hreadyout0, hresp0});
      end
      tick();
      xfer0(32'h102, 1'b1, 3'b010, 32'hFFFFFFFF, rd, rs, waits);
      vecs++;
      if (rs !== 2'b01 || waits !== 1 || err_cnt0 !== 8'd2) begin
         fails++;
         $display("FAIL err_oob_write: got resp=%b waits=%0d cnt=%0d want 01 1 2", rs, waits, err_cnt0);
      end
      xfer0(32'h22, 1'b1, 3'b010, 32'hFFFFFFFF, rd, rs, waits);
      xfer0(32'h21, 1'b1, 3'b001, 32'hFFFFFFFF, rd, rs, waits);
      xfer0(32'h0, 1'b1, 3'b011, 32'hFFFFFFFF, rd, rs, waits);
      vecs++;
      if (rs !== 2'b01 || err_cnt0 !== 8'd5) begin
         fails++;
         $display("FAIL err_align_size: got resp=%b cnt=%0d want 01 5", rs, err_cnt0);
      end
      xfer0(32'h0, 1'b0, 3'b010, 32'h0, rd, rs, waits);
      vecs++;
      if (rd !== 32'h12345678 || rs !== 2'b00) begin
         fails++;
         $display("FAIL err_no_write_w0: got %h resp=%b want 12345678 00", rd, rs);
      end
      xfer0(32'h20, 1'b0, 3'b010, 32'h0, rd, rs, waits);
      vecs++;
      if (rd !== 32'h77EFAA44) begin
         fails++;
         $display("FAIL err_no_write_w8: got %h want 77efaa44", rd);
      end
   endtask

   task automatic test_back_to_back();
      start(1'b0, 1'b1, 32'h0, 1'b1, 3'b010);
      tick();
      HWDATA = 32'h5;
      start(1'b0, 1'b1, 32'h0, 1'b0, 3'b010);
      @(negedge HCLK);
      vecs++;
      if ({hreadyout1, hresp1, hrdata1} !== {1'b1, 2'b00, 32'd0}) begin
         fails++;
         $display("FAIL b2b_write_phase: got %h want %h", {hreadyout1, hresp1, hrdata1},
                  {1'b1, 2'b00, 32'd0});
      end
      tick();
      stop();
      @(negedge HCLK);
      vecs++;
      if ({hreadyout1, hresp1, hrdata1} !== {1'b1, 2'b00, 32'd5}) begin
         fails++;
         $display("FAIL b2b_read_phase: got %h want %h", {hreadyout1, hresp1, hrdata1},
                  {1'b1, 2'b00, 32'd5});
      end
      tick();
      @(negedge HCLK);
      vecs++;
      if (hrdata1 !== 32'd0 || hreadyout1 !== 1'b1) begin
         fails++;
         $display("FAIL b2b_idle: got data=%h rdy=%b want 0 1", hrdata1, hreadyout1);
      end
      tick();
   endtask

   task automatic test_idle_busy();
      logic [7:0] cnt_before;
      cnt_before = err_cnt0;
      for (int i = 0; i < 4; i++) begin
         hsel0  = (i % 2 == 0);
         HTRANS = (i % 2 == 0) ? 2'b01 : 2'b10;
         HADDR  = 32'h100;
         HWRITE = 1'b1;
         HSIZE  = 3'b010;
         tick();
         @(negedge HCLK);
         vecs++;
         if ({hreadyout0, hresp0, hrdata0, err_cnt0} !== {1'b1, 2'b00, 32'd0, cnt_before}) begin
            fails++;
            $display("FAIL idle_busy_%0d: got %h want %h", i, {hreadyout0, hresp0, hrdata0, err_cnt0},
                     {1'b1, 2'b00, 32'd0, cnt_before});
         end
      end
      stop();
      tick();
   endtask

   task automatic test_reset_mid_write();
      logic [31:0] rd;
      logic [1:0]  rs;
      int          waits;
      xfer0(32'h4, 1'b1, 3'b010, 32'h1, rd, rs, waits);
      start(1'b1, 1'b0, 32'h4, 1'b1, 3'b010);
      tick();
      stop();
      HWDATA = 32'hCAFEF00D;
      @(negedge HCLK);
      vecs++;
      if (hreadyout0 !== 1'b0) begin
         fails++;
         $display("FAIL rst_wait_state: got rdy=%b want 0", hreadyout0);
      end
      #2 HRESETn = 1'b0;
      #1;
      vecs++;
      if ({hreadyout0, hresp0, hrdata0, err_cnt0} !== {1'b1, 2'b00, 32'd0, 8'd0}) begin
         fails++;
         $display("FAIL rst_async: got %h want %h", {hreadyout0, hresp0, hrdata0, err_cnt0},
                  {1'b1, 2'b00, 32'd0, 8'd0});
      end
      tick();
      HRESETn = 1'b1;
      tick();
      xfer0(32'h4, 1'b0, 3'b010, 32'h0, rd, rs, waits);
      vecs++;
      if (rd !== 32'h1 || rs !== 2'b00) begin
         fails++;
         $display("FAIL rst_no_commit: got %h resp=%b want 00000001 00", rd, rs);
      end
   endtask

   task automatic test_err_saturate();
      logic [31:0] rd;
      logic [1:0]  rs;
      int          waits;
      for (int i = 0; i < 255; i++)
         xfer0(32'h200, 1'b0, 3'b010, 32'h0, rd, rs, waits);
      vecs++;
      if (err_cnt0 !== 8'd255) begin
         fails++;
         $display("FAIL err_cnt_255: got %0d want 255", err_cnt0);
      end
      xfer0(32'h200, 1'b0, 3'b010, 32'h0, rd, rs, waits);
      vecs++;
      if (err_cnt0 !== 8'd255 || rs !== 2'b01) begin
         fails++;
         $display("FAIL err_cnt_sat: got cnt=%0d resp=%b want 255 01", err_cnt0, rs);
      end
   endtask

   initial begin
      HRESETn = 1'b0;
      hsel0   = 1'b0;
      hsel1   = 1'b0;
      HADDR   = '0;
      HTRANS  = 2'b00;
      HWRITE  = 1'b0;
      HSIZE   = 3'b010;
      HBURST  = 3'b000;
      HPROT   = 4'b0011;
      HWDATA  = '0;
      tick();
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_error();
      test_back_to_back();
      test_idle_busy();
      test_reset_mid_write();
      test_err_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
